// File: rtl/mem_wb_stage.sv
// M/W pipeline register, write-back enables and sticky processor status for the Y86-64 core.
// Optional retired-instruction counter enabled by defining WB_RETIRE_CNT_EN.
module mem_wb_stage #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              stall_i,
  input  logic              bubble_i,
  input  logic [2:0]        m_stat_i,
  input  logic [3:0]        m_icode_i,
  input  logic [DATA_W-1:0] m_valE_i,
  input  logic [DATA_W-1:0] m_valM_i,
  input  logic [3:0]        m_dstE_i,
  input  logic [3:0]        m_dstM_i,
  input  logic              dmem_error_i,
  output logic [2:0]        W_stat_o,
  output logic [3:0]        W_icode_o,
  output logic [DATA_W-1:0] W_valE_o,
  output logic [DATA_W-1:0] W_valM_o,
  output logic [3:0]        W_dstE_o,
  output logic [3:0]        W_dstM_o,
  output logic              w_enE_o,
  output logic              w_enM_o,
  output logic [2:0]        cpu_stat_o,
  output logic              halted_o,
  output logic [CNT_W-1:0]  retired_o
);

  localparam logic [2:0] StatAok = 3'd1;
  localparam logic [2:0] StatAdr = 3'd3;
  localparam logic [3:0] INop    = 4'd1;
  localparam logic [3:0] RNone   = 4'hF;

  logic [2:0]        w_stat_in;
  logic [2:0]        r_W_stat;
  logic [3:0]        r_W_icode;
  logic [DATA_W-1:0] r_W_valE;
  logic [DATA_W-1:0] r_W_valM;
  logic [3:0]        r_W_dstE;
  logic [3:0]        r_W_dstM;
  logic [2:0]        r_cpu_stat;
  logic              w_halted;
  logic              w_w_ok;

  // A data-memory fault only overrides an otherwise healthy instruction.
  assign w_stat_in = (m_stat_i == StatAok && dmem_error_i) ? StatAdr : m_stat_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_W_stat  <= StatAok;
      r_W_icode <= INop;
      r_W_valE  <= '0;
      r_W_valM  <= '0;
      r_W_dstE  <= RNone;
      r_W_dstM  <= RNone;
    end else if (bubble_i) begin
      r_W_stat  <= StatAok;
      r_W_icode <= INop;
      r_W_valE  <= '0;
      r_W_valM  <= '0;
      r_W_dstE  <= RNone;
      r_W_dstM  <= RNone;
    end else if (!stall_i) begin
      r_W_stat  <= w_stat_in;
      r_W_icode <= m_icode_i;
      r_W_valE  <= m_valE_i;
      r_W_valM  <= m_valM_i;
      r_W_dstE  <= m_dstE_i;
      r_W_dstM  <= m_dstM_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cpu_stat <= StatAok;
    end else if (r_cpu_stat == StatAok && r_W_stat != StatAok) begin
      r_cpu_stat <= r_W_stat;
    end
  end

  assign w_halted = (r_cpu_stat != StatAok);
  assign w_w_ok   = (r_W_stat == StatAok) && !w_halted;

  // popq %rsp: both ports target the same register, the loaded value (port M) wins.
  always_comb begin
    w_enM_o = w_w_ok && (r_W_dstM != RNone);
    w_enE_o = w_w_ok && (r_W_dstE != RNone) && (r_W_dstE != r_W_dstM);
  end

`ifdef WB_RETIRE_CNT_EN
  logic             r_new;
  logic [CNT_W-1:0] r_retired;

  // r_new marks W contents loaded from M since the last edge, so a stall never recounts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_new <= 1'b0;
    end else begin
      r_new <= !bubble_i && !stall_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_retired <= '0;
    end else if (r_new && r_W_stat == StatAok && r_cpu_stat == StatAok) begin
      r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign retired_o = r_retired;
`else
  assign retired_o = '0;
`endif

  assign W_stat_o   = r_W_stat;
  assign W_icode_o  = r_W_icode;
  assign W_valE_o   = r_W_valE;
  assign W_valM_o   = r_W_valM;
  assign W_dstE_o   = r_W_dstE;
  assign W_dstM_o   = r_W_dstM;
  assign cpu_stat_o = r_cpu_stat;
  assign halted_o   = w_halted;

endmodule
